// File: rtl/mandelbrot_pixel_sink.sv
// Host-side pacer for the Mandelbrot engine: runs one pixel at a time and packs two 4-bit results per framebuffer byte.
// Optional engine-start timeout with sticky err flag is built when MANDEL_SINK_TIMEOUT_EN is defined.
module mandelbrot_pixel_sink #(
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 240,
  parameter int ADDRWIDTH = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 m_run,
  input  logic                 m_running,
  input  logic [3:0]           m_ctr_out,
  input  logic                 m_finished,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [ADDRWIDTH-1:0] wr_addr,
  output logic [7:0]           wr_data,
  output logic                 err
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_WRITE
  } state_t;

  state_t               state_q;
  logic [PW-1:0]        pix_q;
  logic [3:0]           nib_q;
  logic                 m_run_q;
  logic                 wr_valid_q;
  logic                 frame_done_q;
  logic [ADDRWIDTH-1:0] wr_addr_q;
  logic [7:0]           wr_data_q;

`ifdef MANDEL_SINK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;
`endif

  // Frame end is decided by pixel_index alone; m_finished is informational.
  logic unused_inputs;
  assign unused_inputs = m_finished ^ (TIMEOUT == 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pix_q        <= '0;
      nib_q        <= '0;
      m_run_q      <= 1'b0;
      wr_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
`ifdef MANDEL_SINK_TIMEOUT_EN
      tmo_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pix_q   <= '0;
            m_run_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          m_run_q <= 1'b0;
          state_q <= S_WAIT_START;
`ifdef MANDEL_SINK_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        S_WAIT_START: begin
          if (m_running) state_q <= S_WAIT_DONE;
`ifdef MANDEL_SINK_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            m_run_q <= 1'b1;
            state_q <= S_ISSUE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end
        S_WAIT_DONE: begin
          // Even pixels park in the low nibble; odd pixels complete the byte.
          if (!m_running) begin
            if (!pix_q[0]) begin
              nib_q   <= m_ctr_out;
              pix_q   <= pix_q + PW'(1);
              m_run_q <= 1'b1;
              state_q <= S_ISSUE;
            end else begin
              wr_data_q  <= {m_ctr_out, nib_q};
              wr_addr_q  <= ADDRWIDTH'(pix_q >> 1);
              wr_valid_q <= 1'b1;
              state_q    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (wr_ready) begin
            wr_valid_q <= 1'b0;
            if (pix_q == PW'(NPIX - 1)) begin
              frame_done_q <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              pix_q   <= pix_q + PW'(1);
              m_run_q <= 1'b1;
              state_q <= S_ISSUE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
  assign m_run      = m_run_q;
  assign wr_valid   = wr_valid_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

`ifdef MANDEL_SINK_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mandelbrot_pixel_sink.sv
// Bench for mandelbrot_pixel_sink: small 4x2 frame, randomized engine latency, ctr values and write backpressure.
module tb_mandelbrot_pixel_sink;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;
  localparam int AW   = 4;
  localparam int TMO  = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          m_running = 1'b0;
  logic          m_finished = 1'b0;
  logic          wr_ready = 1'b0;
  logic [3:0]    m_ctr_out = 4'h0;
  logic          busy, frame_done, m_run, wr_valid, err;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0]    ctr_q[$];
  logic [AW-1:0] wq_addr[$];
  logic [7:0]    wq_data[$];
  int fd_cnt = 0, fd_busy_bad = 0, run_rise = 0, run_long = 0;
  int rdy_mode = 0, eng_maxdly = 3, lowcnt = 0;
  bit eng_stall = 1'b0;

  mandelbrot_pixel_sink #(
    .WIDTH(W), .HEIGHT(H), .ADDRWIDTH(AW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .m_run(m_run), .m_running(m_running), .m_ctr_out(m_ctr_out), .m_finished(m_finished),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Engine model: after run, random delay, running high >=2 cycles, then falls with the next ctr value.
  task automatic engine_proc();
    int d, h;
    forever begin
      @(posedge clk); #1;
      if (m_run && !eng_stall) begin
        d = $urandom_range(eng_maxdly, 0);
        h = $urandom_range(4, 2);
        m_finished = 1'b0;
        repeat (d) begin @(posedge clk); #1; end
        m_running = 1'b1;
        m_ctr_out = 4'($urandom);
        repeat (h) begin @(posedge clk); #1; end
        m_running = 1'b0;
        m_ctr_out = (ctr_q.size() != 0) ? ctr_q.pop_front() : 4'h0;
        if (ctr_q.size() == 0) m_finished = 1'b1;
      end
    end
  endtask

  task automatic ready_proc();
    forever begin
      @(posedge clk); #1;
      if (!busy) lowcnt = 0;
      case (rdy_mode)
        0: wr_ready = 1'b1;
        1: wr_ready = 1'($urandom_range(1, 0));
        2: begin
          if (wr_valid && wr_addr == AW'(1) && lowcnt < 5) begin
            wr_ready = 1'b0;
            lowcnt++;
          end else wr_ready = 1'b1;
        end
        default: wr_ready = 1'b0;
      endcase
    end
  endtask

  task automatic monitor_proc();
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_valid && wr_ready) begin
        wq_addr.push_back(wr_addr);
        wq_data.push_back(wr_data);
      end
      if (frame_done) begin
        fd_cnt++;
        if (busy) fd_busy_bad++;
      end
      if (m_run && prev) run_long++;
      if (m_run && !prev) run_rise++;
      prev = m_run;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_frame(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (frame_done) ok = 1'b1;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({m_run, wr_valid, frame_done, busy, err} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 00000", {m_run, wr_valid, frame_done, busy, err});
    end
    n_vec++;
    if (wr_addr !== '0 || wr_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_data: got addr %0h data %0h expected 0 0", wr_addr, wr_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || m_run !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got busy %b m_run %b expected 0 0", busy, m_run);
    end
  endtask

  task automatic test_basic_frame();
    logic [3:0] exp[NPIX];
    int base, fd0, rl0;
    bit ok;
    rdy_mode = 0;
    for (int i = 0; i < NPIX; i++) begin exp[i] = 4'(i + 1); ctr_q.push_back(exp[i]); end
    base = wq_addr.size(); fd0 = fd_cnt; rl0 = run_long;
    pulse_start();
    wait_frame(400, ok);
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL basic_frame_done: got no frame_done expected one within 400 cycles"); end
    n_vec++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy: got %b expected 0", busy); end
    repeat (4) @(negedge clk);
    n_vec++;
    if (wq_addr.size() - base != NPIX / 2) begin
      n_bad++; $display("FAIL basic_writes: got %0d expected %0d", wq_addr.size() - base, NPIX / 2);
    end
    for (int i = 0; i < NPIX / 2 && base + i < wq_addr.size(); i++) begin
      n_vec++;
      if (wq_addr[base+i] !== AW'(i) || wq_data[base+i] !== 8'(exp[2*i] + 16 * exp[2*i+1])) begin
        n_bad++; $display("FAIL basic_write%0d: got addr %0h data %0h expected addr %0h data %0h",
                          i, wq_addr[base+i], wq_data[base+i], i, 8'(exp[2*i] + 16 * exp[2*i+1]));
      end
    end
    n_vec++;
    if (fd_cnt - fd0 != 1 || fd_busy_bad != 0 || run_long != rl0) begin
      n_bad++; $display("FAIL basic_pulses: got frame_done %0d busy_bad %0d long_run %0d expected 1 0 0",
                        fd_cnt - fd0, fd_busy_bad, run_long - rl0);
    end
  endtask

  task automatic test_backpressure();
    int base, lows;
    bit ok;
    rdy_mode = 2; lows = 0; ok = 1'b0;
    for (int i = 0; i < NPIX; i++) ctr_q.push_back(4'(i + 1));
    base = wq_addr.size();
    pulse_start();
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (frame_done) ok = 1'b1;
      if (wr_valid && !wr_ready) begin
        lows++;
        n_vec++;
        if (wr_addr !== AW'(1) || wr_data !== 8'h43 || m_run !== 1'b0) begin
          n_bad++; $display("FAIL stall_hold: got addr %0h data %0h m_run %b expected 1 43 0", wr_addr, wr_data, m_run);
        end
      end
    end
    n_vec++;
    if (!ok || lows != 5) begin
      n_bad++; $display("FAIL stall_cycles: got done %b lows %0d expected 1 5", ok, lows);
    end
    n_vec++;
    if (wq_data.size() - base != NPIX / 2 || wq_data[base+1] !== 8'h43) begin
      n_bad++; $display("FAIL stall_writes: got %0d writes expected %0d with byte1 43", wq_data.size() - base, NPIX / 2);
    end
    rdy_mode = 0;
  endtask

  task automatic test_start_ignored();
    logic [3:0] exp[NPIX];
    int base, fd0;
    bit ok;
    rdy_mode = 1;
    for (int i = 0; i < NPIX; i++) begin exp[i] = 4'($urandom); ctr_q.push_back(exp[i]); end
    base = wq_addr.size(); fd0 = fd_cnt;
    pulse_start();
    repeat (6) @(posedge clk);
    pulse_start();
    repeat (9) @(posedge clk);
    pulse_start();
    wait_frame(400, ok);
    repeat (30) @(negedge clk);
    n_vec++;
    if (!ok || busy !== 1'b0 || fd_cnt - fd0 != 1) begin
      n_bad++; $display("FAIL start_ignored: got done %b busy %b frames %0d expected 1 0 1", ok, busy, fd_cnt - fd0);
    end
    n_vec++;
    if (wq_addr.size() - base != NPIX / 2) begin
      n_bad++; $display("FAIL start_ignored_writes: got %0d expected %0d", wq_addr.size() - base, NPIX / 2);
    end
    for (int i = 0; i < NPIX / 2 && base + i < wq_addr.size(); i++) begin
      n_vec++;
      if (wq_addr[base+i] !== AW'(i) || wq_data[base+i] !== 8'(exp[2*i] + 16 * exp[2*i+1])) begin
        n_bad++; $display("FAIL start_ignored_byte%0d: got %0h expected %0h", i, wq_data[base+i], 8'(exp[2*i] + 16 * exp[2*i+1]));
      end
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid_write();
    logic [3:0] exp[NPIX];
    int base;
    bit ok;
    rdy_mode = 3; ok = 1'b0;
    for (int i = 0; i < NPIX; i++) ctr_q.push_back(4'(i + 1));
    pulse_start();
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (wr_valid) ok = 1'b1;
    end
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL rst_mid_reach_write: got no wr_valid expected one within 200 cycles"); end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (wr_valid !== 1'b0 || m_run !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_async_drop: got valid %b run %b busy %b expected 0 0 0", wr_valid, m_run, busy);
    end
    ctr_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < NPIX; i++) begin exp[i] = 4'($urandom); ctr_q.push_back(exp[i]); end
    base = wq_addr.size();
    pulse_start();
    wait_frame(400, ok);
    repeat (2) @(negedge clk);
    n_vec++;
    if (!ok || wq_addr.size() - base != NPIX / 2) begin
      n_bad++; $display("FAIL rst_restart: got done %b writes %0d expected 1 %0d", ok, wq_addr.size() - base, NPIX / 2);
    end
    for (int i = 0; i < NPIX / 2 && base + i < wq_addr.size(); i++) begin
      n_vec++;
      if (wq_addr[base+i] !== AW'(i) || wq_data[base+i] !== 8'(exp[2*i] + 16 * exp[2*i+1])) begin
        n_bad++; $display("FAIL rst_restart_write%0d: got addr %0h data %0h expected addr %0h data %0h",
                          i, wq_addr[base+i], wq_data[base+i], i, 8'(exp[2*i] + 16 * exp[2*i+1]));
      end
    end
  endtask

  task automatic test_stall();
    int rr0, cnt;
    bit seen;
    eng_stall = 1'b1; seen = 1'b0; cnt = 0;
    rr0 = run_rise;
    pulse_start();
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (m_run) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin n_bad++; $display("FAIL stall_run: got no m_run expected a pulse"); end
`ifdef MANDEL_SINK_TIMEOUT_EN
    for (int c = 0; c < 40 && err !== 1'b1; c++) begin
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (cnt != TMO + 1 || m_run !== 1'b1) begin
      n_bad++; $display("FAIL timeout_err: got err after %0d cycles m_run %b expected %0d 1", cnt, m_run, TMO + 1);
    end
`else
    repeat (40) @(negedge clk);
    cnt = run_rise - rr0;
    n_vec++;
    if (err !== 1'b0 || busy !== 1'b1 || m_run !== 1'b0 || cnt != 1) begin
      n_bad++; $display("FAIL wait_forever: got err %b busy %b m_run %b pulses %0d expected 0 1 0 1", err, busy, m_run, cnt);
    end
`endif
    apply_reset();
    eng_stall = 1'b0;
    @(negedge clk);
    n_vec++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL stall_recover: got err %b busy %b expected 0 0", err, busy);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp[NPIX];
    int base, fd0;
    bit ok;
    for (int f = 0; f < 25; f++) begin
      rdy_mode = (f % 3 == 0) ? 0 : 1;
      eng_maxdly = $urandom_range(4, 0);
      for (int i = 0; i < NPIX; i++) begin exp[i] = 4'($urandom); ctr_q.push_back(exp[i]); end
      base = wq_addr.size(); fd0 = fd_cnt;
      pulse_start();
      wait_frame(500, ok);
      repeat (2) @(negedge clk);
      n_vec++;
      if (!ok || fd_cnt - fd0 != 1 || wq_addr.size() - base != NPIX / 2) begin
        n_bad++; $display("FAIL rand_frame%0d: got done %b frames %0d writes %0d expected 1 1 %0d",
                          f, ok, fd_cnt - fd0, wq_addr.size() - base, NPIX / 2);
      end
      for (int i = 0; i < NPIX / 2 && base + i < wq_addr.size(); i++) begin
        n_vec++;
        if (wq_addr[base+i] !== AW'(i) || wq_data[base+i] !== 8'(exp[2*i] + 16 * exp[2*i+1])) begin
          n_bad++; $display("FAIL rand_frame%0d_write%0d: got addr %0h data %0h expected addr %0h data %0h",
                            f, i, wq_addr[base+i], wq_data[base+i], i, 8'(exp[2*i] + 16 * exp[2*i+1]));
        end
      end
    end
    n_vec++;
    if (run_long != 0 || fd_busy_bad != 0) begin
      n_bad++; $display("FAIL rand_pulse_shape: got long m_run %0d busy-at-done %0d expected 0 0", run_long, fd_busy_bad);
    end
    rdy_mode = 0;
  endtask

  initial begin
    fork
      monitor_proc();
      engine_proc();
      ready_proc();
    join_none
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_write();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mandelbrot_pixel_sink.md
Name: mandelbrot_pixel_sink

Overview:
- Host-side counterpart of the Mandelbrot engine's run/running/ctr_out/finished interface.
- Paces the engine one pixel at a time: issues `run`, waits for the pixel to complete, captures the 4-bit iteration value.
- Packs two pixels per byte and writes them to a framebuffer through a valid/ready write port.
- Sits between the engine and the framebuffer SRAM/VGA side; one `start` pulse produces one full frame.

Parameters:
- WIDTH, 320, pixels per line; must match the engine.
- HEIGHT, 240, lines per frame; must match the engine. WIDTH*HEIGHT must be even.
- ADDRWIDTH, 16, framebuffer byte-address width; must satisfy 2^ADDRWIDTH >= WIDTH*HEIGHT/2.
- TIMEOUT, 15, cycles allowed for `m_running` to rise after `run` (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted.
- m_run  out  1  run request to the engine.
- m_running  in  1  engine busy flag.
- m_ctr_out  in  4  engine iteration value; valid once `m_running` has fallen.
- m_finished  in  1  engine end-of-frame flag.
- wr_valid  out  1  framebuffer write request.
- wr_ready  in  1  framebuffer accepts the write.
- wr_addr  out  ADDRWIDTH  byte address = pixel_index >> 1.
- wr_data  out  8  {odd pixel nibble, even pixel nibble}.
- err  out  1  sticky engine-timeout flag.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - m_run, wr_valid, frame_done, busy, err = 0.
  - wr_addr, wr_data, pixel_index, nibble latch = 0.
- IDLE:
  - start=1 -> clear pixel_index, go ISSUE.
  - start while not IDLE is ignored.
- ISSUE: m_run=1 for exactly one cycle -> WAIT_START.
- WAIT_START: m_run=0; wait for m_running=1 -> WAIT_DONE.
- WAIT_DONE: on the first cycle m_running=0, capture m_ctr_out.
  - Even pixel_index: store in the low-nibble latch, increment pixel_index -> ISSUE. Next m_run asserts 1 cycle after the capture.
  - Odd pixel_index: load wr_data={m_ctr_out, latch} and wr_addr=pixel_index>>1 -> WRITE. wr_valid rises 1 cycle after the capture.
- WRITE:
  - wr_valid=1; wr_addr and wr_data held stable until wr_valid&&wr_ready.
  - On acceptance: deassert wr_valid in the next cycle.
  - If pixel_index==WIDTH*HEIGHT-1: pulse frame_done -> IDLE.
  - Else: increment pixel_index -> ISSUE.
  - wr_ready already high on the cycle wr_valid rises -> single-cycle write.
- m_finished is informational only; frame end is decided by pixel_index. The engine holds finished=1 after the last pixel, which resets its coordinates on the next run.
- pixel_index width: $clog2(WIDTH*HEIGHT). No wrap within a frame; cleared on each new start.
- m_running high on entry to WAIT_START in the same cycle -> proceed normally (no lost pixel).
- Reset mid-frame: all state discarded; in-flight write dropped (wr_valid falls immediately).

Optional Feature:
- Macro: MANDEL_SINK_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_START.
  - If m_running is not seen within TIMEOUT cycles: set err (sticky until reset), return to ISSUE, re-pulse m_run.
- Undefined: err tied 0; WAIT_START waits indefinitely; counter not present.

Test Plan:
- WIDTH=4, HEIGHT=2, engine model returns ctr 1..8, wr_ready=1 -> four writes: addr 0..3, data 0x21, 0x43, 0x65, 0x87; then frame_done pulse, busy=0.
- Same setup, wr_ready low 5 cycles on addr 1 -> wr_addr=1 and wr_data=0x43 stable all 5 cycles; m_run stays 0 until acceptance.
- start pulsed mid-frame -> ignored; exactly 4 writes; exactly one frame_done.
- rst_n asserted during WRITE -> wr_valid, m_run, busy drop asynchronously. A new start after release writes from addr 0.
- MANDEL_SINK_TIMEOUT_EN defined, TIMEOUT=15, m_running held low -> err=1 at cycle 16 after m_run and m_run re-pulses. With the macro undefined -> err stays 0 and the block waits in WAIT_START.
- Default parameters, engine model with random ctr values -> 38400 writes, last wr_addr=38399, frame_done once.
